// File: rtl/ce_sc_demap_if.sv
// Streaming interface of the used-subcarrier demapper: FFT-side sink,
// LS-side source and the FFT size side channel.
interface ce_sc_demap_if #(
    parameter int W_DATA = 16
);
    // FFT-side sink
    logic                     sink_valid;
    logic                     sink_ready;
    logic [1:0]               sink_error;
    logic                     sink_sop;
    logic                     sink_eop;
    logic signed [W_DATA-1:0] sink_real;
    logic signed [W_DATA-1:0] sink_imag;
    logic [11:0]              fftpts_in;

    // LS-side source
    logic                     source_valid;
    logic                     source_ready;
    logic [1:0]               source_error;
    logic                     source_sop;
    logic                     source_eop;
    logic signed [W_DATA-1:0] source_real;
    logic signed [W_DATA-1:0] source_imag;
    logic [11:0]              fftpts_out;

    // Upstream/downstream environment side.
    modport master (
        output sink_valid, sink_error, sink_sop, sink_eop, sink_real, sink_imag,
               fftpts_in, source_ready,
        input  sink_ready, source_valid, source_error, source_sop, source_eop,
               source_real, source_imag, fftpts_out
    );

    // Demapper side.
    modport slave (
        input  sink_valid, sink_error, sink_sop, sink_eop, sink_real, sink_imag,
               fftpts_in, source_ready,
        output sink_ready, source_valid, source_error, source_sop, source_eop,
               source_real, source_imag, fftpts_out
    );
endinterface

// File: rtl/ce_sc_demap.sv
// Used-subcarrier demapper. Takes one natural-order FFT symbol per sop/eop
// frame, drops DC and the guard band, and emits the 2*N_HALF used bins in
// ascending frequency: negative half (forwarded live) first, then the
// positive half, which arrives first and is replayed from a local buffer.
module ce_sc_demap #(
    parameter int W_DATA = 16,
    parameter int N_HALF = 600
) (
    input  logic         clk,
    input  logic         rst,
    ce_sc_demap_if.slave bus
);

    localparam int          AW      = (N_HALF > 1) ? $clog2(N_HALF) : 1;
    localparam int          RW      = $clog2(N_HALF + 1);
    localparam logic [11:0] HALF_N  = 12'(N_HALF);
    localparam logic [11:0] N_MIN   = 12'(2 * N_HALF + 2);
    localparam logic [RW-1:0] RD_LAST = RW'(N_HALF);

    typedef enum logic [2:0] {
        IDLE,
        WR_POS,
        SKIP,
        FWD_NEG,
        READOUT
    } state_t;

    // Frame tracking
    state_t        state_q;
    logic [11:0]   bin_cnt_q;     // bin index of the next non-sop input beat
    logic [RW-1:0] rd_cnt_q;      // next buffer read address during READOUT
    logic [11:0]   fftpts_q;      // N of the frame in progress

    // Registered source stage
    logic                     source_valid_q;
    logic                     source_sop_q;
    logic                     source_eop_q;
    logic [1:0]               source_error_q;
    logic signed [W_DATA-1:0] source_real_q;
    logic signed [W_DATA-1:0] source_imag_q;

    // Positive-half buffer
    logic [2*W_DATA-1:0] mem [N_HALF];
    logic [2*W_DATA-1:0] ram_q;

    logic          en;
    logic          acc;
    logic          n_ok;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [11:0]   fwd_first;
    logic [11:0]   skip_last;
    logic [11:0]   last_bin;

    // The error sideband from the FFT carries nothing this block acts on.
    logic unused_sink_error;
    assign unused_sink_error = ^bus.sink_error;

    // Downstream backpressure freezes the whole block, so the input can only
    // be taken when the output can move and no buffer replay is running.
    assign en             = bus.source_ready;
    assign bus.sink_ready = ~rst & en & (state_q != READOUT);
    assign acc            = bus.sink_valid & bus.sink_ready;

    // Frame geometry derived from the latched N.
    assign fwd_first = fftpts_q - HALF_N;      // first negative-half bin
    assign skip_last = fwd_first - 12'd1;      // last guard/DC bin dropped
    assign last_bin  = fftpts_q - 12'd1;       // bin N-1
    assign n_ok      = (bus.fftpts_in >= N_MIN);

    // Bins 1..N_HALF land at address bin-1.
    assign wr_en   = acc & ~bus.sink_sop & (state_q == WR_POS);
    assign wr_addr = AW'(bin_cnt_q - 12'd1);

    // Address 0 is presented outside READOUT so it is already in ram_q on the
    // first replay cycle; that removes the bubble between bin N-1 and the
    // positive half. The final READOUT cycle has no further address to read.
    assign rd_addr = ((state_q == READOUT) && (rd_cnt_q != RD_LAST)) ? AW'(rd_cnt_q) : '0;

    // Positive-half buffer: written on accepted WR_POS beats, read one cycle
    // ahead of the output register and frozen together with it.
    // NOTE: the RAM array is deliberately left out of reset; every location is
    // rewritten in WR_POS before READOUT can replay it, so reset would only
    // cost a reset net into every storage bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {bus.sink_real, bus.sink_imag};
        end
        if (en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Frame FSM and registered source outputs; everything holds while
    // source_ready is low.
    // NOTE: every register here uses non-blocking assignment, so each branch
    // sees the pre-edge values of state_q, bin_cnt_q and friends regardless
    // of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bin_cnt_q      <= '0;
            rd_cnt_q       <= '0;
            fftpts_q       <= '0;
            source_valid_q <= 1'b0;
            source_sop_q   <= 1'b0;
            source_eop_q   <= 1'b0;
            source_error_q <= 2'b00;
            source_real_q  <= '0;
            source_imag_q  <= '0;
        end else if (en) begin
            // Flags are one-cycle pulses unless a branch below raises them.
            source_valid_q <= 1'b0;
            source_sop_q   <= 1'b0;
            source_eop_q   <= 1'b0;
            source_error_q <= 2'b00;

            case (state_q)
                READOUT: begin
                    source_valid_q <= 1'b1;
                    {source_real_q, source_imag_q} <= ram_q;
                    if (rd_cnt_q == RD_LAST) begin
                        source_eop_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end

                default: begin
                    if (acc) begin
                        if (bus.sink_sop) begin
                            // A sop always (re)starts a frame; interrupting the
                            // negative half is reported since output was already
                            // under way.
                            if (state_q == FWD_NEG) begin
                                source_error_q <= 2'b01;
                            end
                            fftpts_q  <= bus.fftpts_in;
                            bin_cnt_q <= 12'd1;
                            state_q   <= n_ok ? WR_POS : IDLE;
                        end else begin
                            if (state_q != IDLE) begin
                                bin_cnt_q <= bin_cnt_q + 12'd1;
                            end
                            case (state_q)
                                WR_POS: begin
                                    // Bin N-1 can never fall inside WR_POS, so
                                    // any eop here is early.
                                    if (bus.sink_eop) begin
                                        source_error_q <= 2'b10;
                                        state_q        <= IDLE;
                                    end else if (bin_cnt_q == HALF_N) begin
                                        state_q <= SKIP;
                                    end
                                end

                                SKIP: begin
                                    if (bus.sink_eop) begin
                                        source_error_q <= 2'b10;
                                        state_q        <= IDLE;
                                    end else if (bin_cnt_q == skip_last) begin
                                        state_q <= FWD_NEG;
                                    end
                                end

                                FWD_NEG: begin
                                    if (bus.sink_eop && (bin_cnt_q != last_bin)) begin
                                        source_error_q <= 2'b10;
                                        state_q        <= IDLE;
                                    end else begin
                                        source_valid_q <= 1'b1;
                                        source_sop_q   <= (bin_cnt_q == fwd_first);
                                        source_real_q  <= bus.sink_real;
                                        source_imag_q  <= bus.sink_imag;
                                        // Bin N-1 closes the input frame with or
                                        // without an eop flag.
                                        if (bin_cnt_q == last_bin) begin
                                            rd_cnt_q <= RW'(1);
                                            state_q  <= READOUT;
                                        end
                                    end
                                end

                                default: begin
                                    // IDLE: beats outside a frame are dropped.
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.source_valid = source_valid_q;
    assign bus.source_sop   = source_sop_q;
    assign bus.source_eop   = source_eop_q;
    assign bus.source_error = source_error_q;
    assign bus.source_real  = source_real_q;
    assign bus.source_imag  = source_imag_q;
    assign bus.fftpts_out   = fftpts_q;

endmodule

// File: tb/tb_ce_sc_demap.sv
// Directed bench for ce_sc_demap: nominal and back-to-back frames, random
// backpressure, sop/eop protocol errors, undersized N and mid-frame reset.
module tb_ce_sc_demap;

    localparam int W_DATA = 16;
    localparam int N_HALF = 600;
    localparam int N_FFT  = 2048;
    localparam int N_OUT  = 2 * N_HALF;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    bit rand_ready = 1'b0;
    bit rand_valid = 1'b0;
    int in_cyc = 0;           // cycle in which the last driven beat was accepted
    int accept_timeouts = 0;

    ce_sc_demap_if #(.W_DATA(W_DATA)) bus_if ();

    ce_sc_demap #(.W_DATA(W_DATA), .N_HALF(N_HALF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: held high, or 50% random when enabled.
    initial begin
        bus_if.source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_if.source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: collects valid beats and error pulses, and checks that
    // source_* are frozen across every edge where source_ready was low.
    typedef struct {
        logic        sop;
        logic        eop;
        logic [15:0] re;
        logic [15:0] im;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [1:0] err;
        logic       valid;
        int         cyc;
    } err_t;

    beat_t beats[$];
    err_t  errs[$];
    int    stall_viol = 0;
    logic  prev_stall = 1'b0;
    logic [36:0] snap_q = '0;

    wire [36:0] out_snap = {bus_if.source_valid, bus_if.source_sop, bus_if.source_eop,
                            bus_if.source_error, bus_if.source_real, bus_if.source_imag};

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (out_snap !== snap_q)) stall_viol <= stall_viol + 1;
            if (bus_if.source_ready && bus_if.source_valid)
                beats.push_back('{bus_if.source_sop, bus_if.source_eop,
                                  bus_if.source_real, bus_if.source_imag, cyc});
            if (bus_if.source_ready && (bus_if.source_error != 2'b00))
                errs.push_back('{bus_if.source_error, bus_if.source_valid, cyc});
            prev_stall <= ~bus_if.source_ready;
            snap_q     <= out_snap;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_if.sink_valid = 1'b0;
        bus_if.sink_sop   = 1'b0;
        bus_if.sink_eop   = 1'b0;
    endtask

    // Drive one FFT bin k as (k ^ mask, -k) and hold it until accepted.
    task automatic send_beat(input int k, input bit sop, input bit eop,
                             input logic [15:0] mask, input logic [11:0] n);
        bit done;
        int waited;
        if (rand_valid) begin
            while ($urandom_range(0, 9) >= 7) begin
                drive_idle();
                step();
            end
        end
        bus_if.sink_valid = 1'b1;
        bus_if.sink_sop   = sop;
        bus_if.sink_eop   = eop;
        bus_if.sink_real  = 16'(k) ^ mask;
        bus_if.sink_imag  = 16'(-k);
        bus_if.fftpts_in  = n;
        done   = 1'b0;
        waited = 0;
        while (!done && waited < 2000) begin
            @(negedge clk);
            if (bus_if.sink_ready) begin
                done   = 1'b1;
                in_cyc = cyc;
            end
            step();
            waited++;
        end
        if (!done) accept_timeouts++;
        drive_idle();
    endtask

    // Bins from..to; sop on bin 0, eop on eop_bin (-1 for none).
    task automatic send_range(input int from, input int to, input int eop_bin,
                              input logic [15:0] mask, input logic [11:0] n);
        for (int k = from; k <= to; k++) send_beat(k, k == 0, k == eop_bin, mask, n);
    endtask

    task automatic wait_beats(input string tag, input int cnt, input int max_cyc);
        int w;
        w = 0;
        while (beats.size() < cnt && w < max_cyc) begin
            step();
            w++;
        end
        repeat (8) step();
        check(tag, 64'(beats.size()), 64'(cnt));
    endtask

    function automatic logic [33:0] beat_pk(input int idx);
        if (idx < beats.size())
            return {beats[idx].sop, beats[idx].eop, beats[idx].re, beats[idx].im};
        return 'x;
    endfunction

    function automatic int beat_cyc(input int idx);
        if (idx < beats.size()) return beats[idx].cyc;
        return -1;
    endfunction

    function automatic logic [2:0] err_pk(input int idx);
        if (idx < errs.size()) return {errs[idx].err, errs[idx].valid};
        return 'x;
    endfunction

    function automatic int err_cyc(input int idx);
        if (idx < errs.size()) return errs[idx].cyc;
        return -1;
    endfunction

    function automatic logic [33:0] exp_pk(input int b, input bit sop, input bit eop,
                                           input logic [15:0] mask);
        return {sop, eop, 16'(b) ^ mask, 16'(-b)};
    endfunction

    // A complete N_FFT frame: bins N-600..N-1 then 1..600, contiguous.
    task automatic check_frame(input string tag, input int base, input logic [15:0] mask);
        for (int j = 0; j < N_OUT; j++) begin
            int b;
            b = (j < N_HALF) ? (N_FFT - N_HALF + j) : (j - N_HALF + 1);
            check($sformatf("%s[%0d]", tag, j), 64'(beat_pk(base + j)),
                  64'(exp_pk(b, j == 0, j == N_OUT - 1, mask)));
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        errs.delete();
    endtask

    initial begin
        int eop_in;
        int sop2_in;
        int inj_in;
        int w;

        rst = 1'b1;
        drive_idle();
        bus_if.sink_error = 2'b11;
        bus_if.sink_real  = '0;
        bus_if.sink_imag  = '0;
        bus_if.fftpts_in  = 12'(N_FFT);
        repeat (3) step();

        // Reset state
        check("rst_sink_ready",   64'(bus_if.sink_ready),   64'(0));
        check("rst_source_valid", 64'(bus_if.source_valid), 64'(0));
        check("rst_sop_eop",      64'({bus_if.source_sop, bus_if.source_eop}), 64'(0));
        check("rst_data",         64'({bus_if.source_real, bus_if.source_imag}), 64'(0));
        check("rst_error",        64'(bus_if.source_error), 64'(0));
        check("rst_fftpts_out",   64'(bus_if.fftpts_out),   64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_sink_ready", 64'(bus_if.sink_ready), 64'(1));
        step();

        // Nominal frame followed back-to-back by a second frame
        clear_mon();
        send_range(0, N_FFT - 1, N_FFT - 1, 16'h0000, 12'(N_FFT));
        eop_in = in_cyc;
        check("ready_low_after_eop", 64'(bus_if.sink_ready), 64'(0));
        send_beat(0, 1'b1, 1'b0, 16'h7000, 12'(N_FFT));
        sop2_in = in_cyc;
        send_range(1, N_FFT - 1, N_FFT - 1, 16'h7000, 12'(N_FFT));
        wait_beats("b2b_beat_count", 2 * N_OUT, 4000);
        check_frame("nom", 0, 16'h0000);
        check_frame("b2b", N_OUT, 16'h7000);
        check("nom_eop_latency", 64'(beat_cyc(N_OUT - 1) - eop_in), 64'(N_HALF + 1));
        check("nom_contiguous", 64'(beat_cyc(N_OUT - 1) - beat_cyc(0)), 64'(N_OUT - 1));
        check("ready_back_high", 64'(sop2_in - eop_in), 64'(N_HALF + 1));
        // Bins 0..1447 of frame 2 fill the 1448 empty cycles between eop and sop.
        check("b2b_gap", 64'(beat_cyc(N_OUT) - beat_cyc(N_OUT - 1) - 1), 64'(N_FFT - N_HALF));
        check("nom_fftpts_out", 64'(bus_if.fftpts_out), 64'(N_FFT));
        check("nom_errors", 64'(errs.size()), 64'(0));

        // Random backpressure and input gaps
        clear_mon();
        rand_ready = 1'b1;
        rand_valid = 1'b1;
        send_range(0, N_FFT - 1, N_FFT - 1, 16'h0000, 12'(N_FFT));
        wait_beats("rnd_beat_count", N_OUT, 20000);
        rand_ready = 1'b0;
        rand_valid = 1'b0;
        step();
        check_frame("rnd", 0, 16'h0000);
        check("rnd_stall_stable", 64'(stall_viol), 64'(0));

        // sop injected at bin 1500 (negative half already under way)
        clear_mon();
        send_range(0, 1499, -1, 16'h0000, 12'(N_FFT));
        send_beat(0, 1'b1, 1'b0, 16'h7000, 12'(N_FFT));
        inj_in = in_cyc;
        send_range(1, N_FFT - 1, N_FFT - 1, 16'h7000, 12'(N_FFT));
        wait_beats("inj_beat_count", 52 + N_OUT, 4000);
        for (int j = 0; j < 52; j++)
            check($sformatf("inj_partial[%0d]", j), 64'(beat_pk(j)),
                  64'(exp_pk(N_FFT - N_HALF + j, j == 0, 1'b0, 16'h0000)));
        check_frame("inj_next", 52, 16'h7000);
        check("inj_err_count", 64'(errs.size()), 64'(1));
        check("inj_err_code",  64'(err_pk(0)), 64'({2'b01, 1'b0}));
        check("inj_err_cycle", 64'(err_cyc(0) - inj_in), 64'(1));

        // Early eop at bin 1000, then non-sop beats must be ignored in IDLE
        clear_mon();
        send_range(0, 1000, 1000, 16'h0000, 12'(N_FFT));
        repeat (5) step();
        check("early_err_count", 64'(errs.size()), 64'(1));
        check("early_err_code",  64'(err_pk(0)), 64'({2'b10, 1'b0}));
        check("early_no_output", 64'(beats.size()), 64'(0));
        send_range(1, 600, -1, 16'h0000, 12'(N_FFT));
        repeat (10) step();
        check("early_idle_no_output", 64'(beats.size()), 64'(0));
        check("early_idle_no_error",  64'(errs.size()), 64'(1));

        // N = 1024 is too small for 2*600 used bins: the frame is ignored
        clear_mon();
        send_range(0, 1023, 1023, 16'h0000, 12'd1024);
        repeat (20) step();
        check("small_n_no_output", 64'(beats.size()), 64'(0));
        check("small_n_no_error",  64'(errs.size()), 64'(0));

        // Reset during replay at output beat 700, then a clean frame
        clear_mon();
        send_range(0, N_FFT - 1, N_FFT - 1, 16'h0000, 12'(N_FFT));
        w = 0;
        while (beats.size() < 700 && w < 2000) begin
            step();
            w++;
        end
        check("mid_rst_reached_700", 64'(beats.size() >= 700), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus_if.source_valid), 64'(0));
        check("mid_rst_flags", 64'({bus_if.source_sop, bus_if.source_eop, bus_if.source_error}), 64'(0));
        check("mid_rst_data",  64'({bus_if.source_real, bus_if.source_imag}), 64'(0));
        check("mid_rst_fftpts_out", 64'(bus_if.fftpts_out), 64'(0));
        check("mid_rst_sink_ready", 64'(bus_if.sink_ready), 64'(0));
        step();
        step();
        rst = 1'b0;
        step();
        clear_mon();
        send_range(0, N_FFT - 1, N_FFT - 1, 16'h3000, 12'(N_FFT));
        wait_beats("post_rst_beat_count", N_OUT, 4000);
        check_frame("post_rst", 0, 16'h3000);
        check("post_rst_fftpts_out", 64'(bus_if.fftpts_out), 64'(N_FFT));

        check("accept_timeouts", 64'(accept_timeouts), 64'(0));
        check("final_stall_stable", 64'(stall_viol), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
